// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared types and constants for the instruction-fetch stage
package ifetch_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - 32-bit program counter register with sync reset and load enable
module pc_reg #(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_load,
  input  logic [31:0] i_d,
  output logic [31:0] o_q
);

  logic [31:0] r_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: owns the PC, one outstanding
// memory request, holds the fetched instruction until IF/ID accepts it
module ifetch_unit #(
  parameter logic [31:0] RESET_PC  = ifetch_pkg::DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INSTR = ifetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic [31:0] iaddr,
  output logic        ireq,
  input  logic [31:0] ibus,
  input  logic        ivalid,
  output logic [31:0] instruction,
  output logic [31:0] pcPlus4ValOut,
  output logic        fetchValid
);

  import ifetch_pkg::*;

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_instr;
  logic [31:0]  r_pc_plus4;
  logic         r_valid;
  logic [31:0]  w_pc;
  logic [31:0]  w_pc_plus4;
  logic [31:0]  w_pc_next;
  logic         w_pc_load;
  logic         w_capture;
  logic         w_clear;

  pc_reg #(
    .RESET_VAL (RESET_PC & PC_ALIGN_MASK)
  ) u_pc_reg (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_pc_load),
    .i_d    (w_pc_next),
    .o_q    (w_pc)
  );

  assign w_pc_plus4 = w_pc + 32'd4;

  always_comb begin
    w_next_state = r_state;
    w_pc_load    = 1'b0;
    w_pc_next    = w_pc_plus4;
    w_capture    = 1'b0;
    w_clear      = 1'b0;
    if (redirect) begin
      // Redirect wins over any response; an in-flight request must still drain in DROP
      w_pc_load = 1'b1;
      w_pc_next = redirectPc & PC_ALIGN_MASK;
      case (r_state)
        ST_REQ:  w_next_state = ST_REQ;
        ST_WAIT: w_next_state = ivalid ? ST_REQ : ST_DROP;
        ST_HOLD: begin
          w_next_state = ST_REQ;
          w_clear      = 1'b1;
        end
        default: w_next_state = ivalid ? ST_REQ : ST_DROP;
      endcase
    end else begin
      case (r_state)
        ST_REQ:  w_next_state = ST_WAIT;
        ST_WAIT: begin
          if (ivalid) begin
            w_next_state = ST_HOLD;
            w_capture    = 1'b1;
            w_pc_load    = 1'b1;
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            w_next_state = ST_WAIT;
            w_clear      = 1'b1;
          end
        end
        default: begin
          if (ivalid) begin
            w_next_state = ST_REQ;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_REQ;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= 32'h0000_0000;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_capture) begin
        r_instr    <= ibus;
        r_pc_plus4 <= w_pc_plus4;
        r_valid    <= 1'b1;
      end else if (w_clear) begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign ireq          = !reset && !redirect &&
                         (r_state == ST_REQ || (r_state == ST_HOLD && !stall));
  assign iaddr         = w_pc;
  assign instruction   = r_instr;
  assign pcPlus4ValOut = r_pc_plus4;
  assign fetchValid    = r_valid;

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirectPc;
  logic [31:0] iaddr;
  logic        ireq;
  logic [31:0] ibus;
  logic        ivalid;
  logic [31:0] instruction;
  logic [31:0] pcPlus4ValOut;
  logic        fetchValid;

  int checks = 0;
  int errors = 0;

  ifetch_unit dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .redirect      (redirect),
    .redirectPc    (redirectPc),
    .iaddr         (iaddr),
    .ireq          (ireq),
    .ibus          (ibus),
    .ivalid        (ivalid),
    .instruction   (instruction),
    .pcPlus4ValOut (pcPlus4ValOut),
    .fetchValid    (fetchValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL reset_ireq: got %b exp 0", ireq); end
    tick();
    tick();
    #1;
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", fetchValid); end
    checks++; if (instruction !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h exp 00000000", instruction); end
    checks++; if (pcPlus4ValOut !== 32'h0) begin errors++; $display("FAIL reset_pc4: got %h exp 00000000", pcPlus4ValOut); end
    checks++; if (iaddr !== 32'h0) begin errors++; $display("FAIL reset_iaddr: got %h exp 00000000", iaddr); end
    reset = 1'b0;
    #1;
    checks++; if (ireq !== 1'b1) begin errors++; $display("FAIL first_ireq: got %b exp 1", ireq); end
  endtask

  task automatic test_fetch();
    tick();
    #1;
    checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL wait_ireq: got %b exp 0", ireq); end
    ivalid = 1'b1; ibus = 32'h2008_0005;
    tick();
    ivalid = 1'b0;
    #1;
    checks++; if (fetchValid !== 1'b1) begin errors++; $display("FAIL fetch_valid: got %b exp 1", fetchValid); end
    checks++; if (instruction !== 32'h2008_0005) begin errors++; $display("FAIL fetch_instr: got %h exp 20080005", instruction); end
    checks++; if (pcPlus4ValOut !== 32'h4) begin errors++; $display("FAIL fetch_pc4: got %h exp 00000004", pcPlus4ValOut); end
    checks++; if (iaddr !== 32'h4) begin errors++; $display("FAIL fetch_iaddr: got %h exp 00000004", iaddr); end
  endtask

  task automatic test_stall();
    checks++; if (ireq !== 1'b1 || iaddr !== 32'h4) begin errors++; $display("FAIL consume_req: got ireq=%b iaddr=%h exp 1/00000004", ireq, iaddr); end
    tick();
    stall = 1'b1; ivalid = 1'b1; ibus = 32'h8C09_0004;
    tick();
    ivalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (fetchValid !== 1'b1 || instruction !== 32'h8C09_0004 || pcPlus4ValOut !== 32'h8 || ireq !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b i=%h p=%h r=%b exp 1/8c090004/00000008/0", i, fetchValid, instruction, pcPlus4ValOut, ireq);
      end
      tick();
    end
    stall = 1'b0;
    #1;
    checks++; if (ireq !== 1'b1 || iaddr !== 32'h8) begin errors++; $display("FAIL release_req: got ireq=%b iaddr=%h exp 1/00000008", ireq, iaddr); end
    tick();
    #1;
    checks++; if (fetchValid !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL release_clear: got v=%b i=%h exp 0/00000000", fetchValid, instruction); end
  endtask

  task automatic test_redirect_wait();
    redirect = 1'b1; redirectPc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (iaddr !== 32'h100 || ireq !== 1'b0) begin errors++; $display("FAIL drop_entry: got iaddr=%h ireq=%b exp 00000100/0", iaddr, ireq); end
    tick();
    tick();
    ivalid = 1'b1; ibus = 32'hDEAD_BEEF;
    tick();
    ivalid = 1'b0;
    #1;
    checks++; if (fetchValid !== 1'b0) begin errors++; $display("FAIL stale_valid: got %b exp 0", fetchValid); end
    checks++; if (ireq !== 1'b1 || iaddr !== 32'h100) begin errors++; $display("FAIL refetch_req: got ireq=%b iaddr=%h exp 1/00000100", ireq, iaddr); end
    tick();
    stall = 1'b1; ivalid = 1'b1; ibus = 32'h1111_1111;
    tick();
    ivalid = 1'b0;
    #1;
    checks++; if (fetchValid !== 1'b1 || pcPlus4ValOut !== 32'h104 || instruction !== 32'h1111_1111) begin
      errors++; $display("FAIL target_fetch: got v=%b p=%h i=%h exp 1/00000104/11111111", fetchValid, pcPlus4ValOut, instruction);
    end
  endtask

  task automatic test_redirect_hold();
    redirect = 1'b1; redirectPc = 32'h0000_0200;
    #1;
    checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL hold_redir_ireq: got %b exp 0", ireq); end
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (fetchValid !== 1'b0 || instruction !== 32'h0 || iaddr !== 32'h200) begin
      errors++; $display("FAIL hold_flush: got v=%b i=%h a=%h exp 0/00000000/00000200", fetchValid, instruction, iaddr);
    end
    stall = 1'b0;
    #1;
    checks++; if (ireq !== 1'b1) begin errors++; $display("FAIL hold_flush_req: got %b exp 1", ireq); end
  endtask

  task automatic test_redirect_ivalid();
    tick();
    redirect = 1'b1; redirectPc = 32'h0000_0300; ivalid = 1'b1; ibus = 32'h2222_2222;
    tick();
    redirect = 1'b0; ivalid = 1'b0;
    #1;
    checks++; if (ireq !== 1'b1 || iaddr !== 32'h300) begin errors++; $display("FAIL same_cycle_req: got ireq=%b iaddr=%h exp 1/00000300", ireq, iaddr); end
    checks++; if (fetchValid !== 1'b0 || instruction !== 32'h0) begin errors++; $display("FAIL same_cycle_discard: got v=%b i=%h exp 0/00000000", fetchValid, instruction); end
  endtask

  task automatic test_wrap_and_reset();
    redirect = 1'b1; redirectPc = 32'hFFFF_FFFF;
    tick();
    redirect = 1'b0;
    #1;
    checks++; if (iaddr !== 32'hFFFF_FFFC || ireq !== 1'b1) begin errors++; $display("FAIL wrap_req: got iaddr=%h ireq=%b exp fffffffc/1", iaddr, ireq); end
    tick();
    stall = 1'b1; ivalid = 1'b1; ibus = 32'h3333_3333;
    tick();
    ivalid = 1'b0;
    #1;
    checks++; if (pcPlus4ValOut !== 32'h0 || iaddr !== 32'h0 || instruction !== 32'h3333_3333) begin
      errors++; $display("FAIL wrap_fetch: got p=%h a=%h i=%h exp 00000000/00000000/33333333", pcPlus4ValOut, iaddr, instruction);
    end
    stall = 1'b0;
    tick();
    stall = 1'b1; ivalid = 1'b1; ibus = 32'h4444_4444;
    tick();
    ivalid = 1'b0;
    #1;
    checks++; if (pcPlus4ValOut !== 32'h4 || iaddr !== 32'h4) begin errors++; $display("FAIL post_wrap: got p=%h a=%h exp 00000004/00000004", pcPlus4ValOut, iaddr); end
    stall = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++; if (ireq !== 1'b0) begin errors++; $display("FAIL midreset_ireq: got %b exp 0", ireq); end
    tick();
    reset = 1'b0;
    #1;
    checks++; if (fetchValid !== 1'b0 || iaddr !== 32'h0 || pcPlus4ValOut !== 32'h0 || ireq !== 1'b1) begin
      errors++; $display("FAIL midreset_state: got v=%b a=%h p=%h r=%b exp 0/00000000/00000000/1", fetchValid, iaddr, pcPlus4ValOut, ireq);
    end
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirectPc = 32'h0;
    ibus = 32'h0; ivalid = 1'b0;
    test_reset();
    test_fetch();
    test_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_redirect_ivalid();
    test_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
